ret_marker_injector: RTL and testbench

- Inline stage between the fetch/realign frontend and the instruction decoder.
- Watches the 32-bit (already expanded) instruction stream for the function return `jalr x0, 0(x1)`.
- After each return it inserts the marker NOP `addi x0, x0, 1` as the next instruction. Downstream return-marker checking then accepts legacy code that lacks the marker.
- Registered valid/ready stage with one cycle of latency. The marker is inserted by stalling upstream for one beat.

---
 rtl/ret_marker_injector.sv | 132 +++++++++++++
 tb/tb_ret_marker_injector.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ret_marker_injector.sv
// ret_marker_injector: inline stage between fetch/realign and decode.
// Passes the expanded instruction stream through a one-beat valid/ready
// register and inserts the marker NOP after every function return
// (jalr x0, 0(x1)), stalling upstream for one beat per inserted marker.
// Optional build macro: RET_MARKER_SKIP_EXISTING_EN -- an upstream marker
// that directly follows a return is consumed as the marker instead of
// injecting a second one.
module ret_marker_injector #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] RET_INSTR = 32'h00008067,
    parameter logic [31:0] NOP_INSTR = 32'h00100013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              enable_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_instr_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic              in_compressed_i,
    input  logic              in_ex_valid_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_compressed_o,
    output logic              out_ex_valid_o,
    output logic              out_injected_o,
    output logic [CNT_W-1:0]  inject_count_o
);

    typedef enum logic {
        ST_PASS,
        ST_INJECT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] next_addr_q;
    logic              free;
    logic              accept;
    logic              is_ret;
    logic              skip_hit;

    assign free = !out_valid_o || out_ready_i;

`ifdef RET_MARKER_SKIP_EXISTING_EN
    assign skip_hit = (state_q == ST_INJECT) && in_valid_i &&
                      (in_instr_i == NOP_INSTR) && !in_ex_valid_i;
`else
    assign skip_hit = 1'b0;
`endif

    assign in_ready_o = free && !flush_i && ((state_q == ST_PASS) || skip_hit);
    assign accept     = in_valid_i && in_ready_o;
    assign is_ret     = enable_i && (in_instr_i == RET_INSTR) && !in_ex_valid_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_PASS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter INJECT on an accepted return, leave once the marker
    // (or a consumed upstream marker) is loaded; flush forces PASS.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_PASS;
        end else begin
            unique case (state_q)
                ST_PASS:   if (accept && is_ret) state_d = ST_INJECT;
                ST_INJECT: if (free) state_d = ST_PASS;
                default:   state_d = ST_PASS;
            endcase
        end
    end

    // Output register and pending marker address.
    // An accepted beat is loaded the same way in both states: in INJECT the
    // only acceptable beat is an upstream marker, which is never a return,
    // so the return-address latch cannot fire there.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o      <= 1'b0;
            out_instr_o      <= '0;
            out_addr_o       <= '0;
            out_compressed_o <= 1'b0;
            out_ex_valid_o   <= 1'b0;
            out_injected_o   <= 1'b0;
            next_addr_q      <= '0;
        end else if (flush_i) begin
            out_valid_o    <= 1'b0;
            out_injected_o <= 1'b0;
        end else if (accept) begin
            out_valid_o      <= 1'b1;
            out_instr_o      <= in_instr_i;
            out_addr_o       <= in_addr_i;
            out_compressed_o <= in_compressed_i;
            out_ex_valid_o   <= in_ex_valid_i;
            out_injected_o   <= 1'b0;
            if (is_ret) begin
                next_addr_q <= in_addr_i + (in_compressed_i ? ADDR_W'(2) : ADDR_W'(4));
            end
        end else if ((state_q == ST_INJECT) && free) begin
            out_valid_o      <= 1'b1;
            out_instr_o      <= NOP_INSTR;
            out_addr_o       <= next_addr_q;
            out_compressed_o <= 1'b0;
            out_ex_valid_o   <= 1'b0;
            out_injected_o   <= 1'b1;
        end else if (free) begin
            out_valid_o <= 1'b0;
        end
    end

    // Saturating count of injected markers accepted downstream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inject_count_o <= '0;
        end else if (out_valid_o && out_ready_i && out_injected_o &&
                     (inject_count_o != '1)) begin
            inject_count_o <= inject_count_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ret_marker_injector.sv
// Testbench for ret_marker_injector: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a stream-level reference model.
module tb_ret_marker_injector;

    localparam int          AW  = 64;
    localparam int          CW  = 2;
    localparam logic [31:0] RET = 32'h00008067;
    localparam logic [31:0] NOP = 32'h00100013;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          enable_i = 1'b1;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [31:0]   in_instr_i = '0;
    logic [AW-1:0] in_addr_i = '0;
    logic          in_compressed_i = 1'b0;
    logic          in_ex_valid_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [31:0]   out_instr_o;
    logic [AW-1:0] out_addr_o;
    logic          out_compressed_o;
    logic          out_ex_valid_o;
    logic          out_injected_o;
    logic [CW-1:0] inject_count_o;

    always #5 clk_i = ~clk_i;

    ret_marker_injector #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .enable_i(enable_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_instr_i(in_instr_i),
        .in_addr_i(in_addr_i), .in_compressed_i(in_compressed_i),
        .in_ex_valid_i(in_ex_valid_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_instr_o(out_instr_o), .out_addr_o(out_addr_o),
        .out_compressed_o(out_compressed_o), .out_ex_valid_o(out_ex_valid_o),
        .out_injected_o(out_injected_o), .inject_count_o(inject_count_o)
    );

    typedef struct packed {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
        logic          comp;
        logic          ex;
        logic          inj;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         mon_got;
    beat_t         mon_exp;
    int            vectors = 0;
    int            miscompares = 0;
    int            stalls = 0;
    int            model_cnt = 0;
    bit            pend = 0;
    logic [AW-1:0] pend_addr = '0;
    bit            rnd_rdy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every downstream handshake pops one expected beat.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            mon_got = '{out_instr_o, out_addr_o, out_compressed_o, out_ex_valid_o, out_injected_o};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_beat: got unexpected instr=%h addr=%h inj=%0b, expected no beat",
                         mon_got.instr, mon_got.addr, mon_got.inj);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL out_beat: got instr=%h addr=%h c=%0b ex=%0b inj=%0b, expected instr=%h addr=%h c=%0b ex=%0b inj=%0b",
                             mon_got.instr, mon_got.addr, mon_got.comp, mon_got.ex, mon_got.inj,
                             mon_exp.instr, mon_exp.addr, mon_exp.comp, mon_exp.ex, mon_exp.inj);
                end
                if (mon_exp.inj && model_cnt < (2**CW - 1)) model_cnt++;
            end
        end
    end

    // Reference model: each accepted beat goes out unchanged; a qualifying
    // return is followed by a marker at return address + instruction size.
    function automatic beat_t marker(input logic [AW-1:0] a);
        return '{NOP, a, 1'b0, 1'b0, 1'b1};
    endfunction

    task automatic model_accept(input logic [31:0] ins, input logic [AW-1:0] a,
                                input logic c, input logic ex);
        logic [AW-1:0] na;
        exp_q.push_back('{ins, a, c, ex, 1'b0});
        if (enable_i && ins == RET && !ex) begin
            na = a + (c ? 64'd2 : 64'd4);
`ifdef RET_MARKER_SKIP_EXISTING_EN
            pend      = 1;
            pend_addr = na;
`else
            exp_q.push_back(marker(na));
`endif
        end
    endtask

    // With the skip option, the marker is owed unless the beat presented
    // right after the return is already an exception-free marker.
    task automatic resolve();
        if (pend) begin
            pend = 0;
            if (!(in_valid_i && in_instr_i == NOP && !in_ex_valid_i))
                exp_q.push_back(marker(pend_addr));
        end
    endtask

    task automatic tick_neg();
        @(negedge clk_i);
        resolve();
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        if (rnd_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] ins, input logic [AW-1:0] a,
                        input logic c, input logic ex);
        int waited = 0;
        bit done = 0;
        in_valid_i = 1; in_instr_i = ins; in_addr_i = a;
        in_compressed_i = c; in_ex_valid_i = ex;
        while (!done) begin
            tick_neg();
            if (in_ready_o) begin
                done = 1;
                model_accept(ins, a, c, ex);
            end else begin
                stalls++;
                waited++;
                if (waited > 200) begin
                    done = 1;
                    vectors++;
                    miscompares++;
                    $display("FAIL send_timeout: got no in_ready_o in 200 cycles, expected acceptance");
                end
            end
            step();
        end
        in_valid_i = 0;
    endtask

    task automatic drain();
        int waited = 0;
        rnd_rdy = 0;
        out_ready_i = 1;
        while ((exp_q.size() != 0 || pend) && waited < 100) begin
            tick_neg();
            step();
            waited++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_i = 1; in_valid_i = 0; flush_i = 0; rnd_rdy = 0; out_ready_i = 1;
        exp_q.delete(); pend = 0; model_cnt = 0; stalls = 0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_beat", {out_instr_o, 29'd0, out_compressed_o, out_ex_valid_o, out_injected_o}, 64'd0);
        check("rst_out_addr", out_addr_o, 64'd0);
        check("rst_count", 64'(inject_count_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i); #1;
        rst_i = 0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [AW-1:0] a;
        bit last_ret;

        // Basic stream with one return.
        do_reset();
        enable_i = 1;
        send(32'h00000013, 64'h1000, 0, 0);
        send(RET,          64'h1004, 0, 0);
        send(32'h00A00093, 64'h1008, 0, 0);
        drain();
        check("basic_stalls", 64'(stalls), 64'd1);
        tick_neg();
        check("basic_count", 64'(inject_count_o), 64'd1);

        // Compressed return, address wrap, exception return, disabled injection.
        do_reset();
        send(RET, 64'h2002, 1, 0);
        send(RET, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
        send(32'h00000013, 64'h2100, 0, 0);
        send(RET, 64'h2200, 0, 1);
        send(32'h00000013, 64'h2204, 0, 0);
        enable_i = 0;
        send(RET, 64'h2300, 0, 0);
        send(32'h00000013, 64'h2304, 0, 0);
        enable_i = 1;
        drain();
        tick_neg();
        check("misc_count", 64'(inject_count_o), 64'd2);
        check("misc_count_model", 64'(inject_count_o), 64'(model_cnt));

        // Downstream held off while a marker is pending.
        do_reset();
        out_ready_i = 0;
        send(RET, 64'h3000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick_neg();
            check("hold_valid", 64'(out_valid_o), 64'd1);
            check("hold_instr", 64'(out_instr_o), 64'(RET));
            check("hold_in_ready", 64'(in_ready_o), 64'd0);
            step();
        end
        out_ready_i = 1;
        tick_neg();
        step();
        tick_neg();
        check("hold_marker_inj", 64'(out_valid_o && out_injected_o), 64'd1);
        check("hold_marker_addr", out_addr_o, 64'h3004);
        step();
        drain();

        // Flush while a marker is pending.
        do_reset();
        out_ready_i = 0;
        send(RET, 64'h4000, 0, 0);
        flush_i = 1;
        exp_q.delete();
        pend = 0;
        tick_neg();
        check("flush_in_ready", 64'(in_ready_o), 64'd0);
        step();
        flush_i = 0;
        tick_neg();
        check("flush_out_valid", 64'(out_valid_o), 64'd0);
        check("flush_injected", 64'(out_injected_o), 64'd0);
        check("flush_state_pass", 64'(in_ready_o), 64'd1);
        out_ready_i = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            tick_neg();
        end
        check("flush_count", 64'(inject_count_o), 64'd0);
        step();

        // Return followed by an existing marker.
        do_reset();
        send(RET, 64'h5000, 0, 0);
        send(NOP, 64'h5004, 0, 0);
        send(32'h00000013, 64'h5008, 0, 0);
        drain();
        tick_neg();
        check("skip_count_model", 64'(inject_count_o), 64'(model_cnt));
`ifdef RET_MARKER_SKIP_EXISTING_EN
        check("skip_count", 64'(inject_count_o), 64'd0);
`else
        check("skip_count", 64'(inject_count_o), 64'd1);
`endif

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 5; i++) send(RET, 64'h6000 + 64'(8 * i), 0, 0);
        send(32'h00000013, 64'h6100, 0, 0);
        drain();
        tick_neg();
        check("sat_count", 64'(inject_count_o), 64'd3);

        // Randomized traffic with random downstream backpressure.
        do_reset();
        rnd_rdy = 1;
        last_ret = 0;
        for (int n = 0; n < 400; n++) begin
            if (!last_ret) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    tick_neg();
                    step();
                end
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ins = RET;
                4, 5:       ins = NOP;
                6:          ins = 32'h00000013;
                default:    ins = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))
                                            : {$urandom, $urandom};
            enable_i = ($urandom_range(0, 4) != 0);
            in_compressed_i = $urandom_range(0, 1);
            in_ex_valid_i = ($urandom_range(0, 9) == 0);
            last_ret = enable_i && ins == RET && !in_ex_valid_i;
            send(ins, a, in_compressed_i, in_ex_valid_i);
        end
        drain();
        tick_neg();
        check("rand_count", 64'(inject_count_o), 64'(model_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
